sample_window_queue: RTL



---
 rtl/sample_window_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sample_window_queue.sv
// Multi-channel ring buffer that replays the WINDOW most recent samples, oldest first, after each write.
// Optional sticky overrun detection is built when SAMPLE_QUEUE_OVR_DET_EN is defined.
module sample_window_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 1536,
  parameter int unsigned WINDOW = 1021
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wrt_smpl,
  input  logic [NUM_CH*DATA_W-1:0]      new_smpl,
  output logic [NUM_CH*DATA_W-1:0]      smpl_out,
  output logic                          smpl_vld,
  output logic                          smpl_last,
  output logic                          sequencing,
  output logic [$clog2(WINDOW+1)-1:0]   fill_cnt,
  output logic                          ovr
);

  localparam int unsigned SMPL_W = NUM_CH * DATA_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(WINDOW + 1);
  localparam int unsigned RCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ARMED,
    ST_READOUT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SMPL_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [RCNT_W-1:0]   r_rd_cnt;
  logic [FILL_W-1:0]   r_fill_cnt;
  logic                r_pending;
  logic                r_vld;
  logic                r_last;
  logic                r_seq;
  logic [SMPL_W-1:0]   r_rd_data;
  logic [PTR_W-1:0]    w_wr_ptr_nxt;
  logic [PTR_W-1:0]    w_rd_ptr_inc;
  logic [PTR_W-1:0]    w_start;
  logic                w_start_win;
  logic                w_rd_en;
  logic                w_last_addr;
  logic                w_mem_we;

  assign w_mem_we     = wrt_smpl && !rst;
  assign w_wr_ptr_nxt = !wrt_smpl ? r_wr_ptr :
                        (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
  // Window starts WINDOW slots behind the post-write pointer, i.e. at the oldest of the newest WINDOW samples
  assign w_start      = (w_wr_ptr_nxt >= PTR_W'(WINDOW)) ? w_wr_ptr_nxt - PTR_W'(WINDOW)
                                                         : w_wr_ptr_nxt + PTR_W'(DEPTH - WINDOW);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_win = 1'b0;
    w_rd_en     = 1'b0;
    w_last_addr = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (wrt_smpl && (r_fill_cnt == FILL_W'(WINDOW - 1))) begin
          w_start_win = 1'b1;
          w_state_nxt = ST_READOUT;
        end
      end
      ST_ARMED: begin
        if (wrt_smpl) begin
          w_start_win = 1'b1;
          w_state_nxt = ST_READOUT;
        end
      end
      ST_READOUT: begin
        w_rd_en = 1'b1;
        if (r_rd_cnt == RCNT_W'(WINDOW - 1)) begin
          w_last_addr = 1'b1;
          // A write seen during this window (or right now) chains the next window without a gap
          if (r_pending || wrt_smpl) w_start_win = 1'b1;
          else                       w_state_nxt = ST_ARMED;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= new_smpl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_fill_cnt <= '0;
      r_pending  <= 1'b0;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
      r_seq      <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      if (wrt_smpl && (r_fill_cnt != FILL_W'(WINDOW))) r_fill_cnt <= r_fill_cnt + FILL_W'(1);
      if (w_start_win) begin
        r_rd_ptr <= w_start;
        r_rd_cnt <= '0;
      end else if (w_rd_en) begin
        r_rd_ptr <= w_rd_ptr_inc;
        r_rd_cnt <= r_rd_cnt + RCNT_W'(1);
      end
      if (w_last_addr)                              r_pending <= 1'b0;
      else if ((r_state == ST_READOUT) && wrt_smpl) r_pending <= 1'b1;
      r_vld     <= w_rd_en;
      r_last    <= w_last_addr;
      r_seq     <= (w_state_nxt == ST_READOUT) || w_rd_en;
      r_rd_data <= w_rd_en ? r_mem[r_rd_ptr] : '0;
    end
  end

`ifdef SAMPLE_QUEUE_OVR_DET_EN
  localparam int unsigned OVR_LIM = DEPTH - WINDOW - 1;
  localparam int unsigned OCNT_W  = $clog2(DEPTH - WINDOW + 1);

  logic [OCNT_W-1:0] r_ovr_cnt;
  logic              r_ovr;

  // Writes after a window's trigger; beyond OVR_LIM they reach slots still waiting to be read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr_cnt <= '0;
      r_ovr     <= 1'b0;
    end else if (w_start_win) begin
      r_ovr_cnt <= '0;
    end else if ((r_state == ST_READOUT) && wrt_smpl) begin
      if (r_ovr_cnt != OCNT_W'(OVR_LIM + 1)) r_ovr_cnt <= r_ovr_cnt + OCNT_W'(1);
      if (r_ovr_cnt >= OCNT_W'(OVR_LIM))     r_ovr     <= 1'b1;
    end
  end

  assign ovr = r_ovr;
`else
  assign ovr = 1'b0;
`endif

  assign smpl_out   = r_rd_data;
  assign smpl_vld   = r_vld;
  assign smpl_last  = r_last;
  assign sequencing = r_seq;
  assign fill_cnt   = r_fill_cnt;

endmodule
